// File: rtl/timing_sequencer_pkg.sv
// Shared constants and helpers for the timing sequencer.
// Pure declarations: no latency, no flow control.
package timing_sequencer_pkg;

    localparam int SC_WIDTH_DEF = 4;

    function automatic logic [(1<<SC_WIDTH_DEF)-1:0] onehot(input logic [SC_WIDTH_DEF-1:0] v);
        onehot    = '0;
        onehot[v] = 1'b1;
    endfunction

endpackage

// File: rtl/timing_sequencer_decoder_n.sv
// Combinational N-to-2**N one-hot decoder with enable.
// Zero latency; no backpressure (pure logic).
module decoder_n #(
    parameter int N = 4
) (
    input  logic               i_en,
    input  logic [N-1:0]       i_sel,
    output logic [(1<<N)-1:0]  o_dec
);

    always_comb begin
        o_dec = '0;
        if (i_en) begin
            o_dec[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter with run flip-flop and registered one-hot T0..T(N-1) decode.
// t_out registered from next-state so it aligns with sc_out; no backpressure.
module timing_sequencer
    import timing_sequencer_pkg::*;
#(
    parameter int SC_WIDTH  = SC_WIDTH_DEF,
    parameter int MAX_COUNT = (1 << SC_WIDTH) - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       clr,
    input  logic                       inc,
    input  logic                       load,
    input  logic [SC_WIDTH-1:0]        load_val,
    output logic [SC_WIDTH-1:0]        sc_out,
    output logic [(1<<SC_WIDTH)-1:0]   t_out,
    output logic                       running,
    output logic                       wrap,
    output logic                       load_err
);

    localparam int                 NT      = 1 << SC_WIDTH;
    localparam logic [SC_WIDTH-1:0] MAX_VAL = SC_WIDTH'(MAX_COUNT);

    logic [SC_WIDTH-1:0] r_sc;
    logic                r_run;
    logic [NT-1:0]       r_t;
    logic                r_wrap;
    logic                r_lerr;

    logic [SC_WIDTH-1:0] w_sc_next;
    logic                w_run_next;
    logic                w_wrap_next;
    logic                w_lerr_next;
    logic [NT-1:0]       w_t_next;

    assign w_run_next = stop ? 1'b0 : (start ? 1'b1 : r_run);

    // Increment qualifies on the current run state, so stop+inc still counts.
    always_comb begin
        w_sc_next   = r_sc;
        w_wrap_next = 1'b0;
        w_lerr_next = 1'b0;
        if (clr) begin
            w_sc_next = '0;
        end else if (load) begin
            if (load_val > MAX_VAL) begin
                w_lerr_next = 1'b1;
            end else begin
                w_sc_next = load_val;
            end
        end else if (inc && r_run) begin
            if (r_sc == MAX_VAL) begin
                w_sc_next   = '0;
                w_wrap_next = 1'b1;
            end else begin
                w_sc_next = r_sc + 1'b1;
            end
        end
    end

    decoder_n #(
        .N(SC_WIDTH)
    ) u_dec (
        .i_en  (w_run_next),
        .i_sel (w_sc_next),
        .o_dec (w_t_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc   <= '0;
            r_run  <= 1'b0;
            r_t    <= '0;
            r_wrap <= 1'b0;
            r_lerr <= 1'b0;
        end else begin
            r_sc   <= w_sc_next;
            r_run  <= w_run_next;
            r_t    <= w_t_next;
            r_wrap <= w_wrap_next;
            r_lerr <= w_lerr_next;
        end
    end

    assign sc_out   = r_sc;
    assign t_out    = r_t;
    assign running  = r_run;
    assign wrap     = r_wrap;
    assign load_err = r_lerr;

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench: two sequencers (full range and MAX_COUNT=7) on shared stimulus,
// compared each cycle against a behavioural model plus directed checks.
module tb_timing_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, clr, inc, load;
    logic [3:0] load_val;

    logic [3:0]  sc_a, sc_b;
    logic [15:0] t_a, t_b;
    logic        run_a, run_b, wrap_a, wrap_b, lerr_a, lerr_b;

    int n_checks = 0;
    int n_errors = 0;

    int m_sc  [2];
    bit m_run [2];
    bit m_wrap[2];
    bit m_lerr[2];

    always #5 clk = ~clk;

    timing_sequencer #(.SC_WIDTH(4), .MAX_COUNT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr),
        .inc(inc), .load(load), .load_val(load_val), .sc_out(sc_a),
        .t_out(t_a), .running(run_a), .wrap(wrap_a), .load_err(lerr_a)
    );

    timing_sequencer #(.SC_WIDTH(4), .MAX_COUNT(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr),
        .inc(inc), .load(load), .load_val(load_val), .sc_out(sc_b),
        .t_out(t_b), .running(run_b), .wrap(wrap_b), .load_err(lerr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int max_of(input int k);
        return (k == 0) ? 15 : 7;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sc[k] = 0; m_run[k] = 0; m_wrap[k] = 0; m_lerr[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit was_running;
            was_running = m_run[k];
            m_wrap[k] = 0;
            m_lerr[k] = 0;
            if (clr) m_sc[k] = 0;
            else if (load) begin
                if (int'(load_val) > max_of(k)) m_lerr[k] = 1;
                else m_sc[k] = int'(load_val);
            end else if (inc && was_running) begin
                if (m_sc[k] == max_of(k)) begin
                    m_sc[k] = 0;
                    m_wrap[k] = 1;
                end else m_sc[k] = m_sc[k] + 1;
            end
            m_run[k] = stop ? 1'b0 : (start ? 1'b1 : was_running);
        end
    endtask

    task automatic check_one(input string n, input int k, input logic [3:0] sc, input logic [15:0] t,
                             input logic run, input logic wr, input logic le);
        logic [31:0] exp_t;
        exp_t = m_run[k] ? (32'd1 << m_sc[k]) : 32'd0;
        check({n, "_sc"},   {28'd0, sc}, m_sc[k]);
        check({n, "_t"},    {16'd0, t},  exp_t);
        check({n, "_run"},  {31'd0, run}, {31'd0, m_run[k]});
        check({n, "_wrap"}, {31'd0, wr},  {31'd0, m_wrap[k]});
        check({n, "_lerr"}, {31'd0, le},  {31'd0, m_lerr[k]});
    endtask

    task automatic check_all();
        check_one("a", 0, sc_a, t_a, run_a, wrap_a, lerr_a);
        check_one("b", 1, sc_b, t_b, run_b, wrap_b, lerr_b);
    endtask

    // Apply one cycle of inputs, clock, update model, compare both DUTs.
    task automatic step(input bit s, input bit p, input bit c, input bit i, input bit l, input logic [3:0] v);
        start = s; stop = p; clr = c; inc = i; load = l; load_val = v;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        start = 0; stop = 0; clr = 0; inc = 0; load = 0; load_val = 0;
        rst_n = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // Start pulse then continuous inc: full walk and wrap on dut_a.
        step(1, 0, 0, 1, 0, 4'd0);
        check("p1_first_T0", {16'd0, t_a}, 32'h0001);
        for (int n = 1; n <= 15; n++) step(0, 0, 0, 1, 0, 4'd0);
        check("p1_T15", {16'd0, t_a}, 32'h8000);
        check("p1_b_hi_clear", {24'd0, t_b[15:8]}, 32'd0);
        step(0, 0, 0, 1, 0, 4'd0);
        check("p1_wrap_t", {16'd0, t_a}, 32'h0001);
        check("p1_wrap", {31'd0, wrap_a}, 32'd1);
        step(0, 0, 0, 1, 0, 4'd0);
        check("p1_wrap_gone", {31'd0, wrap_a}, 32'd0);

        // Load legal then illegal value on the MAX_COUNT=7 instance.
        step(0, 0, 0, 0, 1, 4'd5);
        check("p3_sc", {28'd0, sc_b}, 32'd5);
        check("p3_t", {16'd0, t_b}, 32'h0020);
        step(0, 0, 0, 0, 1, 4'd9);
        check("p3_hold", {28'd0, sc_b}, 32'd5);
        check("p3_lerr", {31'd0, lerr_b}, 32'd1);
        step(0, 0, 0, 0, 0, 4'd0);
        check("p3_lerr_gone", {31'd0, lerr_b}, 32'd0);

        // clr+inc+load together from sc=3.
        step(0, 0, 0, 0, 1, 4'd3);
        step(0, 0, 1, 1, 1, 4'd6);
        check("p4_sc", {28'd0, sc_b}, 32'd0);
        check("p4_t", {16'd0, t_b}, 32'h0001);
        step(0, 0, 0, 0, 1, 4'd7);
        step(0, 0, 1, 1, 1, 4'd9);
        check("p4_nowrap", {31'd0, wrap_b}, 32'd0);
        check("p4_nolerr", {31'd0, lerr_b}, 32'd0);

        // stop+inc from sc=2, then ignored inc, then restart.
        step(0, 0, 0, 0, 1, 4'd2);
        step(0, 1, 0, 1, 0, 4'd0);
        check("p5_sc", {28'd0, sc_b}, 32'd3);
        check("p5_run", {31'd0, run_b}, 32'd0);
        check("p5_t", {16'd0, t_b}, 32'd0);
        step(0, 0, 0, 1, 0, 4'd0);
        check("p5_halt_inc", {28'd0, sc_b}, 32'd3);
        step(1, 0, 0, 0, 0, 4'd0);
        check("p5_restart", {16'd0, t_b}, 32'h0008);
        step(1, 1, 0, 0, 0, 4'd0);
        check("start_stop", {31'd0, run_b}, 32'd0);

        // Randomized phase.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(99) < 20, $urandom_range(99) < 10, $urandom_range(99) < 5,
                 $urandom_range(99) < 80, $urandom_range(99) < 10, 4'($urandom_range(15)));
        end

        // Asynchronous reset mid-sequence from sc=9.
        step(1, 0, 0, 0, 1, 4'd9);
        check("p6_pre", {28'd0, sc_a}, 32'd9);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 0, 1, 0, 4'd0);
        check("p6_sc", {28'd0, sc_a}, 32'd0);
        check("p6_run", {31'd0, run_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
